// File: rtl/peak_phase_tracker_pkg.sv
// rtl/peak_phase_tracker_pkg.sv - shared constants and FSM encoding for the peak phase tracker
package peak_phase_tracker_pkg;

    localparam int PHASE_FRAC      = 21;
    localparam int K_WIDTH_DEFAULT = 11;
    localparam int N_BINS          = 2 ** K_WIDTH_DEFAULT;

    typedef enum logic [1:0] {
        SCAN = 2'd0,
        READ = 2'd1,
        EMIT = 2'd2
    } state_t;

endpackage

// File: rtl/peak_phase_tracker_if.sv
// rtl/peak_phase_tracker_if.sv - bin stream in, peak/phase report out
interface peak_phase_tracker_if #(
    parameter int PHASE_WIDTH = 24,
    parameter int MAG_WIDTH   = 32,
    parameter int K_WIDTH     = 11
);
    logic [MAG_WIDTH-1:0]   bin_mag;
    logic [PHASE_WIDTH-1:0] bin_phase;
    logic                   bin_valid;
    logic                   bin_last;
    logic                   bin_ready;
    logic [K_WIDTH-1:0]     k_max;
    logic                   k_max_valid;
    logic [PHASE_WIDTH-1:0] phase;
    logic [PHASE_WIDTH-1:0] last_phase;
    logic                   phases_valid;
    logic                   frame_error;

    modport master (
        output bin_mag, bin_phase, bin_valid, bin_last,
        input  bin_ready, k_max, k_max_valid, phase, last_phase, phases_valid, frame_error
    );

    modport slave (
        input  bin_mag, bin_phase, bin_valid, bin_last,
        output bin_ready, k_max, k_max_valid, phase, last_phase, phases_valid, frame_error
    );
endinterface

// File: rtl/peak_phase_tracker_phase_bank_ram.sv
// rtl/peak_phase_tracker_phase_bank_ram.sv - ping-pong phase storage, one write and one registered read port
module phase_bank_ram #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    // No reset on storage or read register so the array maps onto block RAM.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/peak_phase_tracker.sv
// rtl/peak_phase_tracker.sv - per-frame peak bin search with current/previous phase report at that bin
module peak_phase_tracker
    import peak_phase_tracker_pkg::*;
#(
    parameter int PHASE_WIDTH = 24,
    parameter int MAG_WIDTH   = 32,
    parameter int K_WIDTH     = 11,
    parameter int K_MIN       = 1,
    parameter int K_MAX       = 1023
) (
    input  logic                 clock,
    input  logic                 reset_n,
    peak_phase_tracker_if.slave  bus
);

    localparam logic [K_WIDTH-1:0] LAST_IDX = {K_WIDTH{1'b1}};

    state_t                 state;
    logic [K_WIDTH-1:0]     counter;
    logic                   bank_sel;
    logic                   first_frame;
    logic                   len_err;
    logic                   ready_q;

    logic                   peak_found;
    logic [MAG_WIDTH-1:0]   peak_mag;
    logic [K_WIDTH-1:0]     peak_k;
    logic [PHASE_WIDTH-1:0] peak_phase;

    logic [K_WIDTH-1:0]     k_max_q;
    logic [PHASE_WIDTH-1:0] phase_q;
    logic [PHASE_WIDTH-1:0] last_phase_q;
    logic                   valid_q;
    logic                   frame_error_q;

    logic                   xfer;
    logic                   at_last;
    logic                   frame_end;
    logic                   in_range;
    logic                   take_peak;
    logic [31:0]            counter_ext;
    logic [PHASE_WIDTH-1:0] ram_rdata;

    assign counter_ext = {{(32 - K_WIDTH){1'b0}}, counter};
    assign xfer        = bus.bin_valid & ready_q & (state == SCAN);
    assign at_last     = (counter == LAST_IDX);
    assign frame_end   = xfer & (bus.bin_last | at_last);
    assign in_range    = (counter_ext >= 32'(K_MIN)) && (counter_ext <= 32'(K_MAX));
    // Strict greater-than keeps the lower index on ties.
    assign take_peak   = xfer & in_range & (~peak_found | (bus.bin_mag > peak_mag));

    phase_bank_ram #(
        .DATA_WIDTH (PHASE_WIDTH),
        .ADDR_WIDTH (K_WIDTH + 1)
    ) u_ram (
        .clock (clock),
        .we    (xfer),
        .waddr ({bank_sel, counter}),
        .wdata (bus.bin_phase),
        .re    (state == READ),
        .raddr ({~bank_sel, peak_k}),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= SCAN;
            counter       <= '0;
            bank_sel      <= 1'b0;
            first_frame   <= 1'b1;
            len_err       <= 1'b0;
            ready_q       <= 1'b0;
            peak_found    <= 1'b0;
            peak_mag      <= '0;
            peak_k        <= '0;
            peak_phase    <= '0;
            k_max_q       <= '0;
            phase_q       <= '0;
            last_phase_q  <= '0;
            valid_q       <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            valid_q       <= 1'b0;
            frame_error_q <= 1'b0;
            case (state)
                SCAN: begin
                    ready_q <= 1'b1;
                    if (xfer) begin
                        counter <= counter + 1'b1;
                    end
                    if (take_peak) begin
                        peak_found <= 1'b1;
                        peak_mag   <= bus.bin_mag;
                        peak_k     <= counter;
                        peak_phase <= bus.bin_phase;
                    end
                    if (frame_end) begin
                        // Length is wrong whenever bin_last and the final index disagree.
                        len_err <= bus.bin_last ^ at_last;
                        ready_q <= 1'b0;
                        state   <= READ;
                    end
                end
                READ: begin
                    state <= EMIT;
                end
                EMIT: begin
                    if (!first_frame && peak_found) begin
                        valid_q      <= 1'b1;
                        k_max_q      <= peak_k;
                        phase_q      <= peak_phase;
                        last_phase_q <= ram_rdata;
                    end
                    frame_error_q <= len_err | ~peak_found;
                    bank_sel      <= ~bank_sel;
                    first_frame   <= 1'b0;
                    counter       <= '0;
                    len_err       <= 1'b0;
                    peak_found    <= 1'b0;
                    peak_mag      <= '0;
                    peak_k        <= '0;
                    peak_phase    <= '0;
                    ready_q       <= 1'b1;
                    state         <= SCAN;
                end
                default: begin
                    state   <= SCAN;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bin_ready    = ready_q;
    assign bus.k_max        = k_max_q;
    assign bus.phase        = phase_q;
    assign bus.last_phase   = last_phase_q;
    assign bus.phases_valid = valid_q;
    assign bus.k_max_valid  = valid_q;
    assign bus.frame_error  = frame_error_q;

endmodule

// File: tb/tb_peak_phase_tracker.sv
// tb/tb_peak_phase_tracker.sv - directed frames with a scoreboard of expected per-frame reports
module tb_peak_phase_tracker;

    localparam int PW   = 24;
    localparam int MW   = 32;
    localparam int KW   = 4;
    localparam int NB   = 16;
    localparam int KMIN = 1;
    localparam int KMAX = 7;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    peak_phase_tracker_if #(.PHASE_WIDTH(PW), .MAG_WIDTH(MW), .K_WIDTH(KW)) bus ();

    peak_phase_tracker #(
        .PHASE_WIDTH (PW),
        .MAG_WIDTH   (MW),
        .K_WIDTH     (KW),
        .K_MIN       (KMIN),
        .K_MAX       (KMAX)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic          valid;
        logic          err;
        logic [KW-1:0] k;
        logic [PW-1:0] ph;
        logic [PW-1:0] lph;
    } exp_t;

    exp_t          sb [$];
    logic [MW-1:0] mag_a [NB];
    logic [PW-1:0] ph_a  [NB];
    logic [PW-1:0] model_mem [2][NB];
    logic          m_bank;
    logic          m_first;
    int            exp_valids = 0;
    int            seen_valids = 0;
    int            checks = 0;
    int            fails = 0;

    always @(negedge clock) begin
        if (reset_n && bus.phases_valid) seen_valids++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_beats(input int nbeats, input logic use_last);
        for (int i = 0; i < nbeats; i++) begin
            int guard;
            @(negedge clock);
            bus.bin_valid = 1'b1;
            bus.bin_mag   = mag_a[i];
            bus.bin_phase = ph_a[i];
            bus.bin_last  = use_last && (i == nbeats - 1);
            guard = 0;
            while (!bus.bin_ready && guard < 20) begin
                @(negedge clock);
                guard++;
            end
            if (guard >= 20) chk("ready_timeout", 64'(bus.bin_ready), 64'd1);
            @(posedge clock);
        end
    endtask

    task automatic model_frame(input int nbeats, input logic use_last);
        exp_t          e;
        logic          found;
        logic [MW-1:0] pm;
        int            pk;
        found = 1'b0;
        pm    = '0;
        pk    = 0;
        for (int i = 0; i < nbeats; i++) begin
            if (i >= KMIN && i <= KMAX && (!found || mag_a[i] > pm)) begin
                found = 1'b1;
                pm    = mag_a[i];
                pk    = i;
            end
        end
        e.valid = !m_first && found;
        e.err   = (use_last != (nbeats == NB)) || !found;
        e.k     = KW'(pk);
        e.ph    = ph_a[pk];
        e.lph   = model_mem[~m_bank][pk];
        for (int i = 0; i < nbeats; i++) model_mem[m_bank][i] = ph_a[i];
        if (e.valid) exp_valids++;
        m_bank  = ~m_bank;
        m_first = 1'b0;
        sb.push_back(e);
    endtask

    task automatic check_emit();
        exp_t e;
        e = sb.pop_front();
        @(negedge clock);
        bus.bin_valid = 1'b0;
        bus.bin_last  = 1'b0;
        chk("ready_low_c1", 64'(bus.bin_ready), 64'd0);
        chk("valid_early_c1", 64'(bus.phases_valid), 64'd0);
        @(negedge clock);
        chk("ready_low_c2", 64'(bus.bin_ready), 64'd0);
        chk("valid_early_c2", 64'(bus.phases_valid), 64'd0);
        @(negedge clock);
        chk("ready_back", 64'(bus.bin_ready), 64'd1);
        chk("phases_valid", 64'(bus.phases_valid), 64'(e.valid));
        chk("k_max_valid", 64'(bus.k_max_valid), 64'(e.valid));
        chk("frame_error", 64'(bus.frame_error), 64'(e.err));
        if (e.valid) begin
            chk("k_max", 64'(bus.k_max), 64'(e.k));
            chk("phase", 64'(bus.phase), 64'(e.ph));
            chk("last_phase", 64'(bus.last_phase), 64'(e.lph));
        end
        @(negedge clock);
        chk("valid_pulse_end", 64'(bus.phases_valid), 64'd0);
        chk("error_pulse_end", 64'(bus.frame_error), 64'd0);
    endtask

    task automatic send_frame(input int nbeats, input logic use_last);
        model_frame(nbeats, use_last);
        drive_beats(nbeats, use_last);
        check_emit();
    endtask

    initial begin
        bus.bin_valid = 1'b0;
        bus.bin_last  = 1'b0;
        bus.bin_mag   = '0;
        bus.bin_phase = '0;
        m_bank  = 1'b0;
        m_first = 1'b1;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NB; i++) model_mem[b][i] = '0;

        repeat (3) @(negedge clock);
        chk("rst_ready", 64'(bus.bin_ready), 64'd0);
        chk("rst_valid", 64'(bus.phases_valid), 64'd0);
        chk("rst_k_max", 64'(bus.k_max), 64'd0);
        chk("rst_error", 64'(bus.frame_error), 64'd0);
        reset_n = 1'b1;
        #1 chk("ready_after_release", 64'(bus.bin_ready), 64'd0);
        @(negedge clock);
        chk("ready_one_cycle_later", 64'(bus.bin_ready), 64'd1);

        // Frame 1: ramp magnitudes, no report expected.
        for (int i = 0; i < NB; i++) begin mag_a[i] = (i < 8) ? MW'(i * 10) : '0; ph_a[i] = PW'(i * 100); end
        send_frame(NB, 1'b1);
        // Frame 2: k_max 7, phase 705, last_phase 700.
        for (int i = 0; i < NB; i++) ph_a[i] = PW'(i * 100 + 5);
        send_frame(NB, 1'b1);
        // Frame 3: tie at bins 3 and 5.
        for (int i = 0; i < NB; i++) begin mag_a[i] = 1; ph_a[i] = PW'(i * 100 + 7); end
        mag_a[3] = 500; mag_a[5] = 500;
        send_frame(NB, 1'b1);
        // Frame 4: large magnitudes outside the search range.
        for (int i = 0; i < NB; i++) begin mag_a[i] = MW'(i); ph_a[i] = PW'(i * 100 + 11); end
        mag_a[0] = 9999; mag_a[12] = 9999; mag_a[2] = 50;
        send_frame(NB, 1'b1);
        // Frame 5: early bin_last at counter 9.
        for (int i = 0; i < NB; i++) begin mag_a[i] = MW'(i * 3); ph_a[i] = PW'(i * 100 + 13); end
        mag_a[6] = 300;
        send_frame(10, 1'b1);
        // Frame 6: must restart at counter 0.
        for (int i = 0; i < NB; i++) begin mag_a[i] = MW'(16 - i); ph_a[i] = PW'(i * 100 + 17); end
        send_frame(NB, 1'b1);
        // Frame 7: full length without bin_last.
        for (int i = 0; i < NB; i++) begin mag_a[i] = 2; ph_a[i] = PW'(i * 100 + 19); end
        mag_a[4] = 77;
        send_frame(NB, 1'b0);
        // Frame 8: ends on bin 0, nothing in range.
        mag_a[0] = 5;
        send_frame(1, 1'b1);

        // Reset in the middle of a frame.
        for (int i = 0; i < NB; i++) begin mag_a[i] = MW'(i); ph_a[i] = PW'(i * 100 + 23); end
        mag_a[5] = 400;
        drive_beats(6, 1'b0);
        for (int i = 0; i < 6; i++) model_mem[m_bank][i] = ph_a[i];
        @(negedge clock);
        bus.bin_valid = 1'b1;
        bus.bin_mag   = mag_a[6];
        bus.bin_phase = ph_a[6];
        reset_n = 1'b0;
        #1;
        chk("midrst_ready", 64'(bus.bin_ready), 64'd0);
        chk("midrst_k_max", 64'(bus.k_max), 64'd0);
        chk("midrst_phase", 64'(bus.phase), 64'd0);
        chk("midrst_last_phase", 64'(bus.last_phase), 64'd0);
        chk("midrst_valid", 64'(bus.phases_valid), 64'd0);
        bus.bin_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        m_bank  = 1'b0;
        m_first = 1'b1;

        send_frame(NB, 1'b1);
        for (int i = 0; i < NB; i++) begin mag_a[i] = 3; ph_a[i] = PW'(i * 100 + 29); end
        mag_a[6] = 600;
        send_frame(NB, 1'b1);

        repeat (3) @(negedge clock);
        chk("valid_pulse_count", 64'(seen_valids), 64'(exp_valids));
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/peak_phase_tracker.md
Name: peak_phase_tracker

Overview:
- Sits directly upstream of phase_vocoder.
- Consumes the streamed DFT bins of each analysis frame (magnitude plus phase, one bin per accepted beat) and finds the peak-magnitude bin k_max within a search range.
- Stores every bin phase in a ping-pong frame buffer. At frame end it presents k_max, the current-frame phase at k_max and the previous-frame phase at the same k_max as one valid pulse.

Parameters:
- PHASE_WIDTH, 24, signed fixed-point phase width; 21 fractional bits, radians.
- MAG_WIDTH, 32, unsigned bin magnitude width.
- K_WIDTH, 11, bin index width; frame length N = 2**K_WIDTH.
- K_MIN, 1, lowest bin index searched; excludes DC.
- K_MAX, 1023, highest bin index searched; positive frequencies only.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- bin_mag  in  MAG_WIDTH  magnitude of current bin.
- bin_phase  in  PHASE_WIDTH  phase of current bin.
- bin_valid  in  1  bin beat present.
- bin_last  in  1  final bin of frame; qualified by bin_valid.
- bin_ready  out  1  block accepts a beat; transfer = bin_valid & bin_ready.
- k_max  out  K_WIDTH  peak bin index.
- k_max_valid  out  1  one-cycle pulse, identical to phases_valid.
- phase  out  PHASE_WIDTH  current-frame phase at k_max.
- last_phase  out  PHASE_WIDTH  previous-frame phase at k_max.
- phases_valid  out  1  one-cycle pulse.
- frame_error  out  1  one-cycle pulse on a frame-length mismatch.

Behaviour:
- Reset values (async, reset_n low):
  - All outputs 0 except bin_ready.
  - bin_ready = 1 one cycle after reset release.
  - FSM = SCAN, bin counter = 0, bank select = 0, first_frame = 1, peak registers cleared.
- FSM states:
  - SCAN: bin_ready = 1. Each transfer does the following:
    - Writes bin_phase to write bank at address = counter.
    - Increments the counter.
    - Runs the peak compare.
  - Frame end: a transfer with bin_last = 1, or the transfer at counter = N-1, moves SCAN -> READ.
  - READ (1 cycle): bin_ready = 0. Issues a synchronous read of the read bank at address k_max; RAM read latency is 1 cycle.
  - EMIT (1 cycle): bin_ready = 0.
    - Latches last_phase from RAM data.
    - Pulses phases_valid and k_max_valid, unless first_frame = 1.
    - Toggles the bank select, clears first_frame, resets the counter and peak registers, then returns to SCAN.
- Peak compare:
  - Only bins with K_MIN <= index <= K_MAX participate.
  - The first in-range bin loads unconditionally.
  - After that, the peak updates only if bin_mag > stored peak magnitude (strict). A tie therefore keeps the lower index.
  - On each update, phase is captured into a current-phase register. This value goes to the phase output, so no current-bank read is needed.
- Output latency: k_max/phase/last_phase/valid appear exactly 2 cycles after the frame-end transfer. Data outputs hold until the next EMIT.
- First frame after reset: the RAM is written and the banks toggle, but no valid pulse is issued, because the previous bank is undefined.
- Frame-length mismatch:
  - bin_last on a counter value other than N-1 ends the frame early. Unwritten bins in that bank keep stale data.
  - Counter N-1 without bin_last ends the frame anyway.
  - Both cases pulse frame_error in the EMIT cycle; the valid pulse is still issued.
- No in-range bin seen in a frame: no valid pulse is issued, and frame_error pulses.
- bin_valid while bin_ready = 0: the beat is ignored, and the source holds it per the handshake.
- Reset mid-frame discards all state and restarts from the first_frame condition.
- Counter width is K_WIDTH and it never wraps silently, because frame end is forced at N-1.

Decomposition:
- Shared package:
  - Constants PHASE_FRAC = 21 and N_BINS = 2**K_WIDTH.
  - FSM state encoding {SCAN, READ, EMIT}.
- Sub-module phase_bank_ram:
  - Two banks of N x PHASE_WIDTH in one simple dual-port RAM, addressed as {bank_bit, index}.
  - One write port and one synchronous read port; 1-cycle read latency; infers BRAM.

Test Plan (K_WIDTH=4, N=16, K_MIN=1, K_MAX=7):
- Frame 1: bins 0..15 with mag = index*10 for bins 0..7, phase = index*100, bin_last on 15.
  - Required: no valid pulse; bin_ready low for exactly 2 cycles after the bin-15 transfer.
- Frame 2: same magnitudes, phase = index*100 + 5.
  - Required: valid pulse 2 cycles after bin 15, k_max = 7, phase = 705, last_phase = 700.
- Tie: frame 3 with mag[3] = mag[5] = 500 and all other bins 1.
  - Required: k_max = 3, last_phase = frame-2 phase at bin 3 = 305.
- Out-of-range peak: bin 0 mag = 9999 and bin 12 mag = 9999; in-range max is bin 2 = 50.
  - Required: k_max = 2.
- bin_last at counter 9:
  - Required: frame_error pulse in the same cycle as the valid pulse.
  - The next frame starts at counter 0, and its bin_ready deassertion follows the bin-15 transfer.
- reset_n low mid-frame at bin 6, then two full frames:
  - Required: first frame after reset gives no valid pulse; second gives correct k_max/last_phase; outputs read 0 while reset_n is low.
